// File: rtl/gsu_rom_fetch.sv
// gsu_rom_fetch: one-word buffered GSU ROM reader in front of an SDRAM port.
module gsu_rom_fetch #(
  parameter int TIMEOUT = 31,
  parameter bit CLKREF_SYNC = 1'b1
) (
  input  logic        MCLK,
  input  logic        RST,
  input  logic        CLKREF,
  input  logic        INVAL,
  input  logic [22:0] ROM_ADDR,
  input  logic        ROM_OE_N,
  output logic [15:0] ROM_Q,
  output logic        BUSY,
  output logic        SD_REQ,
  output logic [21:0] SD_ADDR,
  input  logic        SD_ACK,
  input  logic [15:0] SD_Q
);
  localparam int CW = $clog2(TIMEOUT + 2);
  typedef enum logic [1:0] {IDLE, ARM, WAIT, FILL} state_t;
  state_t state, state_n;
  logic [15:0] buf_data;
  logic [21:0] buf_tag;
  logic buf_valid, swap, prev_oe_n, pend;
  logic [22:0] prev_addr, lat_addr, pend_addr;
  logic [CW-1:0] cnt;
  logic ev, cur_pend, hit, slot, tmo, done;
  logic [22:0] cur_addr;
  assign ev = !ROM_OE_N && (prev_oe_n || ROM_ADDR != prev_addr);
  assign cur_pend = ev || pend;
  assign cur_addr = ev ? ROM_ADDR : pend_addr;
  // INVAL in the same cycle must not let a stale word count as a hit
  assign hit = buf_valid && !INVAL && cur_addr[22:1] == buf_tag;
  assign slot = CLKREF || !CLKREF_SYNC;
  assign tmo = cnt == CW'(TIMEOUT);
  assign done = SD_ACK || tmo;
  assign ROM_Q = swap ? {buf_data[7:0], buf_data[15:8]} : buf_data;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = (ev && !hit) ? ARM : IDLE;
      ARM:  state_n = slot ? WAIT : ARM;
      WAIT: state_n = done ? FILL : WAIT;
      default: state_n = (cur_pend && !hit) ? ARM : IDLE;
    endcase
  end
  always_ff @(posedge MCLK) begin
    if (RST) begin
      state <= IDLE;
      buf_data <= '0;
      buf_tag <= '0;
      buf_valid <= 1'b0;
      swap <= 1'b0;
      prev_oe_n <= 1'b1;
      prev_addr <= '0;
      lat_addr <= '0;
      pend <= 1'b0;
      pend_addr <= '0;
      cnt <= '0;
      BUSY <= 1'b0;
      SD_REQ <= 1'b0;
      SD_ADDR <= '0;
    end else begin
      state <= state_n;
      prev_oe_n <= ROM_OE_N;
      prev_addr <= ROM_ADDR;
      BUSY <= state_n != IDLE;
      SD_REQ <= state_n == WAIT;
      if (state_n == ARM && state != ARM) lat_addr <= cur_addr;
      if (state == ARM || state == WAIT) begin
        if (ev) begin
          pend <= 1'b1;
          pend_addr <= ROM_ADDR;
        end
      end else pend <= 1'b0;
      if ((state == IDLE && ev && hit) || (state == FILL && cur_pend && hit)) swap <= cur_addr[0];
      if (state == ARM && slot) begin
        SD_ADDR <= lat_addr[22:1];
        cnt <= '0;
      end
      if (state == WAIT && !tmo) cnt <= cnt + 1'b1;
      if (state == WAIT && SD_ACK) begin
        buf_data <= SD_Q;
        buf_tag <= lat_addr[22:1];
        buf_valid <= 1'b1;
        swap <= lat_addr[0];
      end else if (state == WAIT && tmo) begin
        buf_data <= 16'hFFFF;
        buf_valid <= 1'b0;
      end
      if (INVAL) buf_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gsu_rom_fetch.sv
// tb_gsu_rom_fetch: vector table plus cold-miss, hit and timeout sequences.
module tb_gsu_rom_fetch;
  logic MCLK = 1'b0, RST = 1'b1, CLKREF = 1'b0, INVAL = 1'b0, ROM_OE_N = 1'b1, SD_ACK = 1'b0;
  logic [22:0] ROM_ADDR = '0;
  logic [15:0] SD_Q = '0, ROM_Q;
  logic BUSY, SD_REQ;
  logic [21:0] SD_ADDR;
  int n_cmp = 0, n_err = 0, tk = 0;
  bit cref_auto = 1'b0;
  gsu_rom_fetch dut (
    .MCLK(MCLK), .RST(RST), .CLKREF(CLKREF), .INVAL(INVAL), .ROM_ADDR(ROM_ADDR),
    .ROM_OE_N(ROM_OE_N), .ROM_Q(ROM_Q), .BUSY(BUSY), .SD_REQ(SD_REQ),
    .SD_ADDR(SD_ADDR), .SD_ACK(SD_ACK), .SD_Q(SD_Q)
  );
  always #5 MCLK = ~MCLK;
  typedef struct {
    logic rst, cref, inval, oe_n;
    logic [22:0] addr;
    logic ack;
    logic [15:0] sdq;
    logic e_busy, e_req;
    logic [15:0] e_q;
    logic [21:0] e_sa;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge MCLK);
    #1;
    tk++;
    if (cref_auto) CLKREF = (tk % 4 == 0);
  endtask
  task automatic add(input logic rst, cref, inval, oe_n, input logic [22:0] addr, input logic ack,
                     input logic [15:0] sdq, input logic e_busy, e_req, input logic [15:0] e_q,
                     input logic [21:0] e_sa);
    vq.push_back('{rst, cref, inval, oe_n, addr, ack, sdq, e_busy, e_req, e_q, e_sa});
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w, n;
    add(1,0,0,1,23'h000000,0,16'h0000, 0,0,16'h0000,22'h000);
    add(0,0,0,1,23'h000101,0,16'h0000, 0,0,16'h0000,22'h000);
    add(0,0,0,0,23'h000101,0,16'h0000, 1,0,16'h0000,22'h000);
    add(0,0,0,0,23'h000101,0,16'h0000, 1,0,16'h0000,22'h000);
    add(0,1,0,0,23'h000101,0,16'h0000, 1,1,16'h0000,22'h080);
    add(0,0,0,0,23'h000101,0,16'h0000, 1,1,16'h0000,22'h080);
    add(0,0,0,0,23'h000101,1,16'hBEEF, 1,0,16'hEFBE,22'h080);
    add(0,0,0,0,23'h000101,0,16'h0000, 0,0,16'hEFBE,22'h080);
    add(0,0,0,0,23'h000100,0,16'h0000, 0,0,16'hBEEF,22'h080);
    add(0,0,0,1,23'h000100,0,16'h0000, 0,0,16'hBEEF,22'h080);
    add(0,0,0,0,23'h000300,0,16'h0000, 1,0,16'hBEEF,22'h080);
    add(0,1,0,0,23'h000300,0,16'h0000, 1,1,16'hBEEF,22'h180);
    add(0,0,0,0,23'h000400,0,16'h0000, 1,1,16'hBEEF,22'h180);
    add(0,0,0,0,23'h000400,1,16'h1234, 1,0,16'h1234,22'h180);
    add(0,0,0,0,23'h000400,0,16'h0000, 1,0,16'h1234,22'h180);
    add(0,1,0,0,23'h000400,0,16'h0000, 1,1,16'h1234,22'h200);
    add(0,0,0,0,23'h000400,1,16'h5678, 1,0,16'h5678,22'h200);
    add(0,0,0,0,23'h000400,0,16'h0000, 0,0,16'h5678,22'h200);
    add(0,0,0,1,23'h000400,0,16'h0000, 0,0,16'h5678,22'h200);
    add(0,0,0,0,23'h000401,0,16'h0000, 0,0,16'h7856,22'h200);
    add(0,0,0,1,23'h000401,0,16'h0000, 0,0,16'h7856,22'h200);
    add(0,0,0,0,23'h000010,0,16'h0000, 1,0,16'h7856,22'h200);
    add(0,1,0,0,23'h000010,0,16'h0000, 1,1,16'h7856,22'h008);
    add(0,0,1,0,23'h000010,1,16'hCAFE, 1,0,16'hCAFE,22'h008);
    add(0,0,0,0,23'h000010,0,16'h0000, 0,0,16'hCAFE,22'h008);
    add(0,0,0,1,23'h000010,0,16'h0000, 0,0,16'hCAFE,22'h008);
    add(0,0,0,0,23'h000010,0,16'h0000, 1,0,16'hCAFE,22'h008);
    add(0,1,0,0,23'h000010,0,16'h0000, 1,1,16'hCAFE,22'h008);
    add(1,0,0,1,23'h000010,0,16'h0000, 0,0,16'h0000,22'h000);
    add(0,0,0,1,23'h000010,0,16'h0000, 0,0,16'h0000,22'h000);
    add(0,0,0,1,23'h000010,1,16'hDEAD, 0,0,16'h0000,22'h000);
    add(0,0,0,0,23'h000010,0,16'h0000, 1,0,16'h0000,22'h000);
    tick();
    foreach (vq[i]) begin
      RST = vq[i].rst; CLKREF = vq[i].cref; INVAL = vq[i].inval; ROM_OE_N = vq[i].oe_n;
      ROM_ADDR = vq[i].addr; SD_ACK = vq[i].ack; SD_Q = vq[i].sdq;
      tick();
      chk($sformatf("v%0d_busy", i), 32'(BUSY), 32'(vq[i].e_busy));
      chk($sformatf("v%0d_req", i), 32'(SD_REQ), 32'(vq[i].e_req));
      chk($sformatf("v%0d_romq", i), 32'(ROM_Q), 32'(vq[i].e_q));
      chk($sformatf("v%0d_sdaddr", i), 32'(SD_ADDR), 32'(vq[i].e_sa));
    end
    RST = 1; INVAL = 0; SD_ACK = 0; ROM_OE_N = 1; CLKREF = 0;
    tick();
    RST = 0; cref_auto = 1'b1;
    ROM_ADDR = 23'h000101; ROM_OE_N = 0;
    w = 0;
    do begin tick(); w++; end while (!SD_REQ && w < 20);
    chk("cold_req", 32'(SD_REQ), 32'd1);
    chk("cold_sdaddr", 32'(SD_ADDR), 32'h080);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("cold_hold_req", 32'(SD_REQ), 32'd1);
      chk("cold_hold_addr", 32'(SD_ADDR), 32'h080);
    end
    SD_ACK = 1; SD_Q = 16'hBEEF;
    tick();
    SD_ACK = 0; SD_Q = 16'h0000;
    chk("cold_romq", 32'(ROM_Q), 32'hEFBE);
    chk("cold_req_drop", 32'(SD_REQ), 32'd0);
    tick();
    chk("cold_busy_low", 32'(BUSY), 32'd0);
    ROM_ADDR = 23'h000100;
    tick();
    chk("hit_romq", 32'(ROM_Q), 32'hBEEF);
    chk("hit_noreq", 32'(SD_REQ), 32'd0);
    chk("hit_busy", 32'(BUSY), 32'd0);
    tick();
    chk("hit_noreq2", 32'(SD_REQ | BUSY), 32'd0);
    cref_auto = 1'b0; CLKREF = 1;
    ROM_OE_N = 1;
    tick();
    ROM_ADDR = 23'h000800; ROM_OE_N = 0;
    tick();
    tick();
    chk("tmo_req", 32'(SD_REQ), 32'd1);
    n = 0;
    while (SD_REQ && n < 100) begin tick(); n++; end
    chk("tmo_len_ok", 32'(n >= 31 && n <= 33), 32'd1);
    chk("tmo_romq", 32'(ROM_Q), 32'hFFFF);
    tick();
    chk("tmo_busy_low", 32'(BUSY), 32'd0);
    ROM_OE_N = 1;
    tick();
    ROM_OE_N = 0;
    tick();
    tick();
    chk("tmo_reissue", 32'(SD_REQ), 32'd1);
    chk("tmo_reissue_addr", 32'(SD_ADDR), 32'h400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gsu_rom_fetch.md
GSU_ROM_FETCH -- requirements
Module: gsu_rom_fetch

Interface
REQ-001 SHALL have parameter TIMEOUT, default 31, meaning the MCLK cycles allowed between SD_REQ assertion and SD_ACK before the fetch is abandoned.
REQ-002 SHALL have parameter CLKREF_SYNC, default 1: 1 = a new SDRAM request is issued only in a cycle with CLKREF=1; 0 = issued immediately.
REQ-003 SHALL have ports:
- MCLK  in  1  clock; all logic on the rising edge
- RST  in  1  synchronous reset, active-high
- CLKREF  in  1  SDRAM slot-alignment strobe
- INVAL  in  1  one-cycle pulse; drops the word buffer (mapper change, cart reload)
- ROM_ADDR  in  23  byte address from the GSU mapper, already masked
- ROM_OE_N  in  1  mapper read strobe, active-low
- ROM_Q  out  16  [7:0] = addressed byte, [15:8] = other byte of the same word
- BUSY  out  1  high while a miss is outstanding
- SD_REQ  out  1  SDRAM read request, level
- SD_ADDR  out  22  SDRAM word address (ROM_ADDR[22:1])
- SD_ACK  in  1  one-cycle pulse; SD_Q valid in that cycle
- SD_Q  in  16  SDRAM read word, little-endian (byte 0 on [7:0])

Function
REQ-004 SHALL hold a one-word buffer: BUF_DATA 16 b, BUF_TAG 22 b, BUF_VALID 1 b.
REQ-005 SHALL detect a read event in any cycle with ROM_OE_N=0 and either ROM_OE_N=1 in the previous cycle or ROM_ADDR differing from its previous-cycle value.
REQ-006 SHALL treat a read event with BUF_VALID=1 and ROM_ADDR[22:1]=BUF_TAG as a hit: no SDRAM traffic, and ROM_Q reflects the byte from the next edge.
REQ-007 SHALL present ROM_Q as the buffered word, byte-swapped when the latched ROM_ADDR[0]=1, so the addressed byte is always on [7:0].
REQ-008 SHALL use the FSM states IDLE, ARM, WAIT and FILL.
- IDLE --(miss)--> ARM: latch ROM_ADDR; BUSY=1.
- ARM --(CLKREF=1, or CLKREF_SYNC=0)--> WAIT: SD_REQ=1; SD_ADDR = latched address[22:1]; timeout counter cleared.
- WAIT --(SD_ACK)--> FILL: capture SD_Q into BUF_DATA; set BUF_TAG; BUF_VALID=1; SD_REQ=0.
- WAIT --(counter reaches TIMEOUT with no ack)--> FILL: BUF_DATA=16'hFFFF; BUF_VALID=0; SD_REQ=0.
- FILL --> IDLE: BUSY=0 on this edge.
REQ-009 SHALL hold SD_REQ and SD_ADDR stable for the whole of WAIT.
REQ-010 SHALL ignore SD_ACK outside WAIT.
REQ-011 SHALL give a miss a latency of 1 + CLKREF wait + ack delay + 1 cycles from the read event to valid ROM_Q and BUSY low.
REQ-012 SHALL handle a read event during ARM, WAIT or FILL by latching it as pending (last address wins). In FILL, a pending event is re-evaluated as a hit or miss, and a pending miss goes directly to ARM instead of IDLE.
REQ-013 SHALL clear BUF_VALID on INVAL in any state. If INVAL coincides with SD_ACK, the captured word is still output but BUF_VALID ends at 0.
REQ-014 SHALL ignore ROM_OE_N rising (read aborted) while in ARM or WAIT: the fetch completes and fills the buffer.
REQ-015 SHALL use a timeout counter that saturates and never wraps.

Reset
REQ-016 SHALL, on RST=1 at an edge, force: state=IDLE, SD_REQ=0, BUSY=0, ROM_Q=16'h0000, SD_ADDR=0, BUF_VALID=0, pending cleared, counter=0.
REQ-017 SHALL give RST priority over all other inputs, including mid-WAIT: SD_REQ drops on that same edge, and a later SD_ACK is ignored.

Verification
REQ-018 SHALL pass a cold miss: ROM_ADDR=0x000101, OE_N falls, CLKREF every 4th cycle, ACK 6 cycles after REQ with SD_Q=0xBEEF -> SD_ADDR=0x000080, then ROM_Q=0xEFBE and BUSY low one cycle after ACK.
REQ-019 SHALL pass a hit: after REQ-018, ROM_ADDR=0x000100 -> no SD_REQ, ROM_Q=0xBEEF on the next edge.
REQ-020 SHALL pass a timeout: no SD_ACK for TIMEOUT cycles -> SD_REQ drops, ROM_Q=0xFFFF, and a re-read of the same address reissues SD_REQ.
REQ-021 SHALL pass a back-to-back miss: address changes to 0x000400 during WAIT -> first fill completes, FSM goes FILL->ARM, second SD_ADDR=0x000200.
REQ-022 SHALL pass a mid-operation reset: RST asserted in WAIT -> SD_REQ=0 and BUSY=0 next edge, and an ACK two cycles later leaves BUF_VALID=0 and ROM_Q=0.
REQ-023 SHALL pass an INVAL/ACK collision: INVAL and SD_ACK in the same cycle -> ROM_Q shows data, and a repeat read of the same address misses.
